// File: rtl/mem_resp.sv
// mem_resp: halfword-wide synchronous memory responder for the CPU memory port.
// Read data is registered (one-cycle latency). A streaming loader fills the
// array from halfword 0 upward. The CPU port is blocked while a load is
// in progress.
module mem_resp #(
  parameter  int MEM_DEPTH  = 2**12,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [0:1][7:0]       i_mem_di,
  input  logic                  i_mem_en,
  input  logic                  i_mem_rd_en,
  input  logic [0:1]            i_mem_wr_en,
  output logic [0:1][7:0]       o_mem_do,
  input  logic                  i_ld_start,
  input  logic                  i_ld_valid,
  input  logic [15:0]           i_ld_data,
  input  logic                  i_ld_last,
  output logic                  o_ld_ready,
  output logic                  o_ld_busy,
  output logic                  o_ld_done,
  output logic [ADDR_WIDTH-1:0] o_ld_count
);

  localparam int IDX_W = ADDR_WIDTH - 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

  // Storage is split per byte lane so that lane strobes map onto independent writes.
  logic [7:0] mem_lane0_r [MEM_DEPTH];
  logic [7:0] mem_lane1_r [MEM_DEPTH];

  logic [1:0]            state_r;
  logic [1:0]            state_nx_s;
  logic                  ld_ready_r;
  logic                  ld_busy_r;
  logic                  ld_done_r;
  logic [ADDR_WIDTH-1:0] ld_count_r;
  logic [0:1][7:0]       mem_do_r;

  logic [IDX_W-1:0]      cpu_idx_s;
  logic                  cpu_active_s;
  logic                  beat_s;
  logic                  final_beat_s;
  logic                  wr0_s;
  logic                  wr1_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [7:0]            wr_d0_s;
  logic [7:0]            wr_d1_s;
  logic                  unused_addr_lsb_s;

  // Address bit 0 selects a byte within the halfword, which is never needed here.
  assign unused_addr_lsb_s = i_mem_addr[0];
  assign cpu_idx_s         = i_mem_addr[ADDR_WIDTH-1:1];
  assign cpu_active_s      = (state_r == ST_IDLE);
  assign beat_s            = (state_r == ST_LOAD) & ld_ready_r & i_ld_valid;
  // A load also ends when the top halfword is written; the index never wraps.
  assign final_beat_s      = beat_s & (i_ld_last | (ld_count_r == LAST_IDX));

  // Next-state decode for the loader sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_ld_start) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (final_beat_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Select the single write source for this cycle: CPU in IDLE, loader in LOAD.
  always_comb begin
    wr0_s    = 1'b0;
    wr1_s    = 1'b0;
    wr_idx_s = cpu_idx_s;
    wr_d0_s  = i_mem_di[0];
    wr_d1_s  = i_mem_di[1];
    if (rst) begin
      wr0_s = 1'b0;
      wr1_s = 1'b0;
    end else if (cpu_active_s) begin
      wr0_s = i_mem_en & i_mem_wr_en[0];
      wr1_s = i_mem_en & i_mem_wr_en[1];
    end else if (beat_s) begin
      wr0_s    = 1'b1;
      wr1_s    = 1'b1;
      wr_idx_s = ld_count_r[IDX_W-1:0];
      wr_d0_s  = i_ld_data[15:8];
      wr_d1_s  = i_ld_data[7:0];
    end else begin
      wr0_s = 1'b0;
      wr1_s = 1'b0;
    end
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr0_s) begin
      mem_lane0_r[wr_idx_s] <= wr_d0_s;
    end
    if (wr1_s) begin
      mem_lane1_r[wr_idx_s] <= wr_d1_s;
    end
  end

  // Registered read data: read-first in IDLE, zero while the port is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_do_r <= 16'h0000;
    end else if (i_mem_en & i_mem_rd_en) begin
      if (cpu_active_s) begin
        mem_do_r <= {mem_lane0_r[cpu_idx_s], mem_lane1_r[cpu_idx_s]};
      end else begin
        mem_do_r <= 16'h0000;
      end
    end
  end

  // Loader state, count and registered status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ld_ready_r <= 1'b0;
      ld_busy_r  <= 1'b0;
      ld_done_r  <= 1'b0;
      ld_count_r <= '0;
    end else begin
      state_r    <= state_nx_s;
      ld_ready_r <= (state_nx_s == ST_LOAD);
      ld_busy_r  <= (state_nx_s != ST_IDLE);
      ld_done_r  <= (state_nx_s == ST_DONE);
      if (cpu_active_s && i_ld_start) begin
        ld_count_r <= '0;
      end else if (beat_s) begin
        ld_count_r <= ld_count_r + ADDR_WIDTH'(1);
      end
    end
  end

  assign o_mem_do   = mem_do_r;
  assign o_ld_ready = ld_ready_r;
  assign o_ld_busy  = ld_busy_r;
  assign o_ld_done  = ld_done_r;
  assign o_ld_count = ld_count_r;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp with a small (8-halfword) array: directed vector table,
// hand-written loader corner cases, then random traffic against a model.
module tb_mem_resp;

  localparam int DEPTH = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic [15:0]   di;
  logic          en;
  logic          rd;
  logic [1:0]    wr;
  logic [15:0]   mdo;
  logic          start;
  logic          valid;
  logic [15:0]   data;
  logic          last;
  logic          ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] m_mem [DEPTH];
  logic        m_loading;
  logic        m_finishing;
  int          m_count;
  logic [15:0] m_do;

  mem_resp #(.MEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_mem_addr (addr),
    .i_mem_di   (di),
    .i_mem_en   (en),
    .i_mem_rd_en(rd),
    .i_mem_wr_en(wr),
    .o_mem_do   (mdo),
    .i_ld_start (start),
    .i_ld_valid (valid),
    .i_ld_data  (data),
    .i_ld_last  (last),
    .o_ld_ready (ready),
    .o_ld_busy  (busy),
    .o_ld_done  (done),
    .o_ld_count (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Apply the rules for one clock edge given the current inputs.
  task automatic model_edge();
    int idx;
    idx = int'(addr) / 2;
    if (rst) begin
      m_loading   = 1'b0;
      m_finishing = 1'b0;
      m_count     = 0;
      m_do        = 16'h0000;
    end else if (!m_loading && !m_finishing) begin
      if (en && rd) m_do = m_mem[idx];
      if (en && wr[1]) m_mem[idx][15:8] = di[15:8];
      if (en && wr[0]) m_mem[idx][7:0]  = di[7:0];
      if (start) begin
        m_loading = 1'b1;
        m_count   = 0;
      end
    end else if (m_loading) begin
      if (en && rd) m_do = 16'h0000;
      if (valid) begin
        m_mem[m_count] = data;
        m_count++;
        if (last || m_count == DEPTH) begin
          m_loading   = 1'b0;
          m_finishing = 1'b1;
        end
      end
    end else begin
      if (en && rd) m_do = 16'h0000;
      m_finishing = 1'b0;
    end
  endtask

  // One clock: update model, advance DUT, compare all outputs.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("m_do",    {16'h0000, mdo}, {16'h0000, m_do});
    check("m_ready", {31'h0, ready}, {31'h0, m_loading});
    check("m_busy",  {31'h0, busy},  {31'h0, (m_loading | m_finishing)});
    check("m_done",  {31'h0, done},  {31'h0, m_finishing});
    check("m_count", {28'h0, count}, m_count);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; en = 1'b0; rd = 1'b0; wr = 2'b00; addr = 4'h0; di = 16'h0000;
    start = 1'b0; valid = 1'b0; data = 16'h0000; last = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a);
    idle_inputs();
    en = 1'b1; rd = 1'b1; addr = a;
  endtask

  typedef struct {
    logic        rst, en, rd;
    logic [1:0]  wr;
    logic [3:0]  addr;
    logic [15:0] di;
    logic        start, valid;
    logic [15:0] data;
    logic        last;
    logic [15:0] e_do;
    int          e_cnt;
    logic        e_rdy, e_busy, e_done;
  } vec_t;

  vec_t tbl [22];

  initial begin
    idle_inputs();
    rst = 1'b1;
    m_loading = 1'b0; m_finishing = 1'b0; m_count = 0; m_do = 16'h0000;

    //            rst   en    rd    wr     addr   di        st    vld   data      last  e_do      cnt rdy   busy  done
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'h4, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hABCD, 0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'b10, 4'h4, 16'h1122, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hABCD, 0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h5, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h11CD, 0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'b11, 4'h8, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h11CD, 0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'b11, 4'h8, 16'h5678, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234, 0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h8, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'b11, 4'h8, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h8, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h4, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h11CD, 0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 1'b1, 16'hA001, 1'b0, 16'h11CD, 1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'h8, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h11CD, 1, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b1, 1'b1, 16'hA002, 1'b0, 16'h0000, 2, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 1'b1, 16'hA003, 1'b1, 16'h0000, 3, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 3, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hA001, 3, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h2, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hA002, 3, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hA003, 3, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'h8, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5678, 3, 1'b0, 1'b0, 1'b0};

    // Directed vectors
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; rd = tbl[i].rd; wr = tbl[i].wr;
      addr = tbl[i].addr; di = tbl[i].di; start = tbl[i].start;
      valid = tbl[i].valid; data = tbl[i].data; last = tbl[i].last;
      step();
      check($sformatf("v%0d_do", i),    {16'h0000, mdo}, {16'h0000, tbl[i].e_do});
      check($sformatf("v%0d_count", i), {28'h0, count},  tbl[i].e_cnt);
      check($sformatf("v%0d_ready", i), {31'h0, ready},  {31'h0, tbl[i].e_rdy});
      check($sformatf("v%0d_busy", i),  {31'h0, busy},   {31'h0, tbl[i].e_busy});
      check($sformatf("v%0d_done", i),  {31'h0, done},   {31'h0, tbl[i].e_done});
    end

    // Full-memory load with no last marker
    idle_inputs();
    start = 1'b1;
    step();
    check("full_start_ready", {31'h0, ready}, 32'd1);
    check("full_start_count", {28'h0, count}, 32'd0);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid = 1'b1; data = 16'hB000 + 16'(i);
      step();
      check("full_count", {28'h0, count}, i + 1);
    end
    check("full_ready_low", {31'h0, ready}, 32'd0);
    check("full_done",      {31'h0, done},  32'd1);
    data = 16'hC0C0;
    step();
    check("full_extra_busy",  {31'h0, busy},  32'd0);
    check("full_extra_count", {28'h0, count}, 32'd8);
    step();
    check("full_extra_count2", {28'h0, count}, 32'd8);
    check("full_extra_done",   {31'h0, done},  32'd0);
    cpu_read(4'h0);
    step();
    check("full_hw0", {16'h0000, mdo}, 32'h0000B000);
    cpu_read(4'hE);
    step();
    check("full_hw7", {16'h0000, mdo}, 32'h0000B007);

    // Reset in the middle of a load
    idle_inputs();
    start = 1'b1;
    step();
    start = 1'b0; valid = 1'b1; data = 16'hD100;
    step();
    data = 16'hD101;
    step();
    check("mid_count2", {28'h0, count}, 32'd2);
    valid = 1'b0; rst = 1'b1;
    step();
    check("rst_busy",  {31'h0, busy},  32'd0);
    check("rst_ready", {31'h0, ready}, 32'd0);
    check("rst_count", {28'h0, count}, 32'd0);
    check("rst_do",    {16'h0000, mdo}, 32'h0);
    cpu_read(4'h0);
    step();
    check("rst_hw0", {16'h0000, mdo}, 32'h0000D100);
    cpu_read(4'h2);
    step();
    check("rst_hw1", {16'h0000, mdo}, 32'h0000D101);
    cpu_read(4'h4);
    step();
    check("rst_hw2", {16'h0000, mdo}, 32'h0000B002);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      en    = 1'($urandom_range(0, 1));
      rd    = 1'($urandom_range(0, 1));
      wr    = 2'($urandom_range(0, 3));
      addr  = 4'($urandom_range(0, 15));
      di    = 16'($urandom);
      start = ($urandom_range(0, 9) == 0);
      valid = 1'($urandom_range(0, 1));
      data  = 16'($urandom);
      last  = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
